// File: rtl/router_reg_param.sv
// ----------------------------------------------------------------------------
// router_reg_param
//
// Parametrised datapath register stage of the router. It sits between the
// source interface and the per-port FIFOs and is sequenced by the router FSM
// through one-hot state strobes.
//
// Functions:
//   - latches the packet header on a valid destination address
//   - steers header, payload and parity bytes onto dout
//   - parks one byte in a hold register while the selected FIFO is full
//   - accumulates running XOR parity and flags a parity mismatch
//   - counts accepted payload bytes (saturating)
//   - optional header length check, enabled by defining ROUTER_REG_LEN_CHECK_EN
//
// Parameters:
//   DATA_W     byte width in bits (>= ADDR_W+2)
//   ADDR_W     width of the destination field, header[ADDR_W-1:0]
//   NUM_PORTS  number of output ports; valid addresses 0..NUM_PORTS-1
//
// Ports:
//   clock          system clock, rising edge
//   resetn         asynchronous active-low reset
//   pkt_valid      source data valid; low on the parity byte
//   data_in        source byte
//   fifo_full      selected FIFO full
//   rst_int_reg    FSM strobe: clear low_pkt_valid
//   detect_add     FSM state DECODE_ADDRESS
//   lfd_state      FSM state LOAD_FIRST_DATA
//   ld_state       FSM state LOAD_DATA
//   laf_state      FSM state LOAD_AFTER_FULL
//   full_state     FSM state FIFO_FULL_STATE
//   dout           byte to FIFO
//   parity_done    packet parity byte captured
//   low_pkt_valid  pkt_valid seen low during load
//   err            parity mismatch (valid one cycle after parity_done)
//   hold_valid     hold register occupied
//   byte_cnt       payload bytes accepted in the current packet
//   len_err        length mismatch (constant 0 without ROUTER_REG_LEN_CHECK_EN)
// ----------------------------------------------------------------------------
module router_reg_param #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 2,
    parameter int NUM_PORTS = 3
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     pkt_valid,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     fifo_full,
    input  logic                     rst_int_reg,
    input  logic                     detect_add,
    input  logic                     lfd_state,
    input  logic                     ld_state,
    input  logic                     laf_state,
    input  logic                     full_state,
    output logic [DATA_W-1:0]        dout,
    output logic                     parity_done,
    output logic                     low_pkt_valid,
    output logic                     err,
    output logic                     hold_valid,
    output logic [DATA_W-ADDR_W-1:0] byte_cnt,
    output logic                     len_err
);

    localparam int                CNT_W      = DATA_W - ADDR_W;
    localparam logic [ADDR_W:0]   PORT_LIMIT = (ADDR_W + 1)'(NUM_PORTS);
    localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    // Running parity accumulation step.
    function automatic logic [DATA_W-1:0] parity_acc(
        input logic [DATA_W-1:0] acc,
        input logic [DATA_W-1:0] data
    );
        return acc ^ data;
    endfunction

    // Saturating payload counter increment; sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] res;
        if (cnt == CNT_MAX) begin
            res = cnt;
        end else begin
            res = cnt + CNT_ONE;
        end
        return res;
    endfunction

    // State registers
    logic [DATA_W-1:0] header_r,      header_s;
    logic [DATA_W-1:0] hold_r,        hold_s;
    logic [DATA_W-1:0] int_parity_r,  int_parity_s;
    logic [DATA_W-1:0] pkt_parity_r,  pkt_parity_s;
    logic [DATA_W-1:0] dout_r,        dout_s;
    logic [CNT_W-1:0]  byte_cnt_r,    byte_cnt_s;
    logic              parity_done_r, parity_done_s;
    logic              err_r,         err_s;
    logic              err_pend_r,    err_pend_s;
    logic              hold_valid_r,  hold_valid_s;
    logic              low_pkt_valid_r, low_pkt_valid_s;

    // Prioritised state decode: detect_add > lfd_state > ld_state > laf_state.
    logic cap_s;
    logic lfd_act_s;
    logic ld_act_s;
    logic laf_act_s;

    assign cap_s     = detect_add && pkt_valid &&
                       ({1'b0, data_in[ADDR_W-1:0]} < PORT_LIMIT);
    assign lfd_act_s = !detect_add && lfd_state;
    assign ld_act_s  = !detect_add && !lfd_state && ld_state;
    assign laf_act_s = !detect_add && !lfd_state && !ld_state && laf_state;

    // Next-state logic for header, datapath, parity and counter.
    always_comb begin
        header_s      = header_r;
        hold_s        = hold_r;
        int_parity_s  = int_parity_r;
        pkt_parity_s  = pkt_parity_r;
        dout_s        = dout_r;
        byte_cnt_s    = byte_cnt_r;
        parity_done_s = parity_done_r;
        err_s         = err_r;
        hold_valid_s  = hold_valid_r;
        // err_pend is a one-cycle marker following the rise of parity_done.
        err_pend_s    = 1'b0;

        // Parity verdict one cycle after parity_done rises; a header capture
        // in the same cycle wins and starts a clean packet.
        if (err_pend_r && !cap_s) begin
            err_s = (pkt_parity_r != int_parity_r);
        end else begin
            err_s = err_r;
        end

        if (detect_add) begin
            if (cap_s) begin
                header_s      = data_in;
                int_parity_s  = {DATA_W{1'b0}};
                byte_cnt_s    = {CNT_W{1'b0}};
                parity_done_s = 1'b0;
                err_s         = 1'b0;
                hold_valid_s  = 1'b0;
            end else begin
                // Invalid destination or no valid data: nothing changes.
                header_s = header_r;
            end
        end else if (lfd_act_s) begin
            dout_s       = header_r;
            int_parity_s = parity_acc(int_parity_r, header_r);
        end else if (ld_act_s) begin
            if (fifo_full) begin
                hold_s       = data_in;
                hold_valid_s = 1'b1;
            end else begin
                dout_s = data_in;
            end

            if (pkt_valid && !full_state) begin
                int_parity_s = parity_acc(int_parity_r, data_in);
                byte_cnt_s   = sat_inc(byte_cnt_r);
            end else begin
                byte_cnt_s = byte_cnt_r;
            end

            // Parity byte: captured even when it is parked in hold.
            if (!pkt_valid && !parity_done_r) begin
                pkt_parity_s  = data_in;
                parity_done_s = 1'b1;
                err_pend_s    = 1'b1;
            end else begin
                pkt_parity_s = pkt_parity_r;
            end
        end else if (laf_act_s) begin
            if (hold_valid_r) begin
                dout_s       = hold_r;
                hold_valid_s = 1'b0;
            end else begin
                dout_s = dout_r;
            end

            if (low_pkt_valid_r && !parity_done_r) begin
                parity_done_s = 1'b1;
                err_pend_s    = 1'b1;
            end else begin
                parity_done_s = parity_done_r;
            end
        end else begin
            dout_s = dout_r;
        end
    end

    // Next-state logic for low_pkt_valid; rst_int_reg has priority.
    always_comb begin
        low_pkt_valid_s = low_pkt_valid_r;
        if (rst_int_reg) begin
            low_pkt_valid_s = 1'b0;
        end else if (ld_act_s && !pkt_valid) begin
            low_pkt_valid_s = 1'b1;
        end else begin
            low_pkt_valid_s = low_pkt_valid_r;
        end
    end

    // Register bank with asynchronous clear.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            header_r        <= {DATA_W{1'b0}};
            hold_r          <= {DATA_W{1'b0}};
            int_parity_r    <= {DATA_W{1'b0}};
            pkt_parity_r    <= {DATA_W{1'b0}};
            dout_r          <= {DATA_W{1'b0}};
            byte_cnt_r      <= {CNT_W{1'b0}};
            parity_done_r   <= 1'b0;
            err_r           <= 1'b0;
            err_pend_r      <= 1'b0;
            hold_valid_r    <= 1'b0;
            low_pkt_valid_r <= 1'b0;
        end else begin
            header_r        <= header_s;
            hold_r          <= hold_s;
            int_parity_r    <= int_parity_s;
            pkt_parity_r    <= pkt_parity_s;
            dout_r          <= dout_s;
            byte_cnt_r      <= byte_cnt_s;
            parity_done_r   <= parity_done_s;
            err_r           <= err_s;
            err_pend_r      <= err_pend_s;
            hold_valid_r    <= hold_valid_s;
            low_pkt_valid_r <= low_pkt_valid_s;
        end
    end

`ifdef ROUTER_REG_LEN_CHECK_EN
    logic len_err_r, len_err_s;

    // Length verdict: accepted payload count against header length field,
    // evaluated together with the parity verdict.
    always_comb begin
        len_err_s = len_err_r;
        if (cap_s) begin
            len_err_s = 1'b0;
        end else if (err_pend_r) begin
            len_err_s = (byte_cnt_r != header_r[DATA_W-1:ADDR_W]);
        end else begin
            len_err_s = len_err_r;
        end
    end

    // Length error register with asynchronous clear.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            len_err_r <= 1'b0;
        end else begin
            len_err_r <= len_err_s;
        end
    end

    assign len_err = len_err_r;
`else
    assign len_err = 1'b0;
`endif

    assign dout          = dout_r;
    assign parity_done   = parity_done_r;
    assign low_pkt_valid = low_pkt_valid_r;
    assign err           = err_r;
    assign hold_valid    = hold_valid_r;
    assign byte_cnt      = byte_cnt_r;

endmodule

// File: tb/tb_router_reg_param.sv
module tb_router_reg_param;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;
    localparam int CNT_W  = DATA_W - ADDR_W;

    logic              clock;
    logic              resetn;
    logic              pkt_valid;
    logic [DATA_W-1:0] data_in;
    logic              fifo_full;
    logic              rst_int_reg;
    logic              detect_add;
    logic              lfd_state;
    logic              ld_state;
    logic              laf_state;
    logic              full_state;
    logic [DATA_W-1:0] dout;
    logic              parity_done;
    logic              low_pkt_valid;
    logic              err;
    logic              hold_valid;
    logic [CNT_W-1:0]  byte_cnt;
    logic              len_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] pl_q[$];
    int         full_mode = 0;   // 0 never full, 1 random, 2 at full_idx
    int         full_idx  = -1;

    router_reg_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_PORTS(3)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .pkt_valid    (pkt_valid),
        .data_in      (data_in),
        .fifo_full    (fifo_full),
        .rst_int_reg  (rst_int_reg),
        .detect_add   (detect_add),
        .lfd_state    (lfd_state),
        .ld_state     (ld_state),
        .laf_state    (laf_state),
        .full_state   (full_state),
        .dout         (dout),
        .parity_done  (parity_done),
        .low_pkt_valid(low_pkt_valid),
        .err          (err),
        .hold_valid   (hold_valid),
        .byte_cnt     (byte_cnt),
        .len_err      (len_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        pkt_valid   = 1'b0;
        data_in     = 8'h00;
        fifo_full   = 1'b0;
        rst_int_reg = 1'b0;
        detect_add  = 1'b0;
        lfd_state   = 1'b0;
        ld_state    = 1'b0;
        laf_state   = 1'b0;
        full_state  = 1'b0;
    endtask

    // Drives one complete packet (header, payload in pl_q, parity byte) the way
    // the router FSM sequences it, and checks against packet-level expectations.
    task automatic run_pkt(input logic [7:0] hdr, input bit bad_par);
        logic [7:0] par_x;
        logic [7:0] par_byte;
        logic [7:0] b;
        logic [7:0] last;
        logic [5:0] len_field;
        int         n;
        int         exp_cnt;
        bit         stall;
        bit         stall_last;
        bit         exp_len_err;

        n = pl_q.size();
        par_x = hdr;
        foreach (pl_q[i]) par_x = par_x ^ pl_q[i];
        par_byte  = bad_par ? (par_x ^ 8'h01) : par_x;
        exp_cnt   = (n > 63) ? 63 : n;
        len_field = hdr[7:2];
`ifdef ROUTER_REG_LEN_CHECK_EN
        exp_len_err = (exp_cnt != int'(len_field));
`else
        exp_len_err = 1'b0;
`endif
        stall_last = 1'b0;

        idle_inputs();
        detect_add = 1'b1;
        pkt_valid  = 1'b1;
        data_in    = hdr;
        tick();
        check("cap_byte_cnt", byte_cnt, 0);
        check("cap_parity_done", parity_done, 0);
        check("cap_err", err, 0);
        check("cap_hold_valid", hold_valid, 0);
        check("cap_len_err", len_err, 0);

        detect_add = 1'b0;
        lfd_state  = 1'b1;
        data_in    = pl_q[0];
        tick();
        check("lfd_dout", dout, hdr);
        lfd_state = 1'b0;
        last = hdr;

        for (int i = 0; i <= n; i++) begin
            b = (i < n) ? pl_q[i] : par_byte;
            if (full_mode == 1) stall = ($urandom_range(0, 3) == 0);
            else stall = (full_mode == 2) && (i == full_idx);
            ld_state  = 1'b1;
            pkt_valid = (i < n);
            data_in   = b;
            fifo_full = stall;
            tick();
            if (stall) begin
                check("stall_dout_holds", dout, last);
                check("stall_hold_valid", hold_valid, 1);
                if (i == n) check("stall_parity_done", parity_done, 1);
                ld_state   = 1'b0;
                fifo_full  = 1'b0;
                full_state = 1'b1;
                tick();
                full_state = 1'b0;
                laf_state  = 1'b1;
                tick();
                laf_state = 1'b0;
                check("laf_dout", dout, b);
                check("laf_hold_valid", hold_valid, 0);
            end else begin
                check("ld_dout", dout, b);
            end
            if (i == n) stall_last = stall;
            last = b;
        end
        check("parity_done", parity_done, 1);
        check("low_pkt_valid_set", low_pkt_valid, 1);
        if (!stall_last) check("err_not_yet", err, 0);

        ld_state    = 1'b0;
        pkt_valid   = 1'b0;
        rst_int_reg = 1'b1;
        tick();
        rst_int_reg = 1'b0;
        check("err", err, bad_par);
        check("byte_cnt", byte_cnt, exp_cnt);
        check("len_err", len_err, exp_len_err);
        check("low_pkt_valid_clr", low_pkt_valid, 0);
        tick();
        check("err_sticky", err, bad_par);
        check("parity_done_sticky", parity_done, 1);
    endtask

    initial begin
        logic [7:0] hdr;
        int         n;

        idle_inputs();
        resetn = 1'b0;
        tick();
        tick();
        check("rst_dout", dout, 0);
        check("rst_byte_cnt", byte_cnt, 0);
        check("rst_parity_done", parity_done, 0);
        check("rst_err", err, 0);
        check("rst_hold_valid", hold_valid, 0);
        check("rst_low_pkt_valid", low_pkt_valid, 0);
        check("rst_len_err", len_err, 0);
        resetn = 1'b1;
        tick();

        // Good packet: 0D, 11, 22, 33, parity 0D.
        full_mode = 0;
        pl_q = '{8'h11, 8'h22, 8'h33};
        run_pkt(8'h0D, 1'b0);

        // Same packet with corrupt parity byte 0C.
        run_pkt(8'h0D, 1'b1);

        // Invalid address 3: header kept, state untouched.
        idle_inputs();
        detect_add = 1'b1;
        pkt_valid  = 1'b1;
        data_in    = 8'h0F;
        tick();
        check("badaddr_parity_done", parity_done, 1);
        check("badaddr_err", err, 1);
        detect_add = 1'b0;
        lfd_state  = 1'b1;
        tick();
        check("badaddr_lfd_dout", dout, 8'h0D);
        idle_inputs();
        tick();

        // FIFO full on the second payload byte, then on the parity byte.
        full_mode = 2;
        full_idx  = 1;
        run_pkt(8'h0D, 1'b0);
        full_idx  = 3;
        run_pkt(8'h0D, 1'b0);

        // Length field 4 with only 3 payload bytes.
        full_mode = 0;
        run_pkt(8'h11, 1'b0);

        // Saturation: 70 payload bytes, length field 63.
        pl_q.delete();
        for (int i = 0; i < 70; i++) pl_q.push_back(8'($urandom_range(0, 255)));
        run_pkt(8'hFC, 1'b1);

        // Mid-packet reset with a byte parked in hold.
        idle_inputs();
        detect_add = 1'b1;
        pkt_valid  = 1'b1;
        data_in    = 8'h0E;
        tick();
        detect_add = 1'b0;
        lfd_state  = 1'b1;
        data_in    = 8'hAA;
        tick();
        lfd_state = 1'b0;
        ld_state  = 1'b1;
        tick();
        data_in   = 8'hBB;
        fifo_full = 1'b1;
        tick();
        check("pre_rst_byte_cnt", byte_cnt, 2);
        check("pre_rst_hold_valid", hold_valid, 1);
        resetn = 1'b0;
        #1;
        check("async_rst_dout", dout, 0);
        check("async_rst_byte_cnt", byte_cnt, 0);
        check("async_rst_hold_valid", hold_valid, 0);
        check("async_rst_parity_done", parity_done, 0);
        check("async_rst_err", err, 0);
        idle_inputs();
        tick();
        resetn = 1'b1;
        tick();
        pl_q = '{8'h01, 8'h02};
        run_pkt(8'h09, 1'b0);

        // Randomised packets with random FIFO-full stalls.
        full_mode = 1;
        for (int k = 0; k < 20; k++) begin
            n = $urandom_range(1, 6);
            pl_q.delete();
            for (int i = 0; i < n; i++) pl_q.push_back(8'($urandom_range(0, 255)));
            hdr[1:0] = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) hdr[7:2] = 6'(n);
            else hdr[7:2] = 6'($urandom_range(0, 63));
            run_pkt(hdr, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/router_reg_param.md
Name: router_reg_param

Overview:
Parametrised datapath register stage of the router, the successor to the fixed 8-bit register block. It sits between the source interface and the per-port FIFOs. Under control of the router FSM it:
- latches the header,
- steers header, payload and parity bytes onto dout,
- parks one byte in a hold register when the FIFO is full,
- computes running XOR parity and flags a parity error.
It adds generic width and port count, a payload byte counter, and an optional header-length check.

Parameters:
DATA_W, 8, data/byte width in bits (>= ADDR_W+2)
ADDR_W, 2, width of destination-address field in header bits [ADDR_W-1:0]
NUM_PORTS, 3, number of output ports; valid addresses are 0..NUM_PORTS-1 (NUM_PORTS <= 2**ADDR_W)

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
pkt_valid  in  1  source data valid; falls on the parity byte
data_in  in  DATA_W  source byte
fifo_full  in  1  selected FIFO full
rst_int_reg  in  1  FSM: clear low_pkt_valid
detect_add  in  1  FSM: DECODE_ADDRESS state
lfd_state  in  1  FSM: LOAD_FIRST_DATA state
ld_state  in  1  FSM: LOAD_DATA state
laf_state  in  1  FSM: LOAD_AFTER_FULL state
full_state  in  1  FSM: FIFO_FULL_STATE state
dout  out  DATA_W  byte to FIFO
parity_done  out  1  packet parity byte captured
low_pkt_valid  out  1  pkt_valid seen low during load
err  out  1  parity mismatch
hold_valid  out  1  hold register occupied
byte_cnt  out  DATA_W-ADDR_W  payload bytes accepted in current packet
len_err  out  1  length mismatch (tied 0 without macro)

Behaviour:
- Reset: async, active-low; all outputs and internal registers (header, hold, int_parity, pkt_parity, err_pend) go to 0 immediately. Mid-packet reset aborts the packet; no residue survives.
- Header capture:
  - Condition: detect_add && pkt_valid && data_in[ADDR_W-1:0] < NUM_PORTS.
  - Action: header<=data_in; int_parity, byte_cnt, parity_done, err, len_err, hold_valid <= 0.
  - Invalid address: nothing changes.
- FSM state inputs are one-hot by contract. If several are asserted, priority is detect_add > lfd_state > ld_state > laf_state.
- dout update rules (dout holds otherwise):
  - lfd_state: dout<=header.
  - ld_state && !fifo_full: dout<=data_in.
  - ld_state && fifo_full: hold<=data_in, hold_valid<=1; dout holds.
  - laf_state && hold_valid: dout<=hold, hold_valid<=0.
  - laf_state && !hold_valid: dout holds.
- Internal parity:
  - lfd_state: int_parity ^= header.
  - ld_state && pkt_valid && !full_state: int_parity ^= data_in.
- byte_cnt: increments on ld_state && pkt_valid && !full_state; saturates at all-ones and does not wrap.
- Packet parity:
  - ld_state && !pkt_valid && !parity_done: pkt_parity<=data_in, parity_done<=1. This also applies when fifo_full is high; the byte goes to hold in that case.
  - laf_state && low_pkt_valid && !parity_done: parity_done<=1.
  - parity_done stays 1 until the next header capture or reset.
- err:
  - err_pend is set in the cycle parity_done rises.
  - Next cycle: err <= (pkt_parity != int_parity); err_pend clears.
  - err is valid 1 cycle after parity_done and stays sticky until the next header capture.
- low_pkt_valid: rst_int_reg clears it (priority); otherwise ld_state && !pkt_valid sets it.
- Latency: every output is registered, one cycle from qualifying input.

Optional Feature:
ROUTER_REG_LEN_CHECK_EN
- Defined: length field is header[DATA_W-1:ADDR_W]. In the same cycle err is evaluated, len_err <= (byte_cnt != length field). len_err is sticky until the next header capture.
- Undefined: len_err tied 0; no comparator logic.

Test Plan:
1. Defaults; header 8'h0D (len 3, addr 1), payload 11,22,33, parity 0D, no full -> dout sequence 0D,11,22,33,0D; parity_done=1; err=0 one cycle later; byte_cnt=3.
2. Same packet with parity 0C -> err=1 one cycle after parity_done; err stays 1 until the next header capture clears it.
3. detect_add, pkt_valid, data_in=8'h0F (addr 3, NUM_PORTS=3) -> header not captured; a following lfd_state drives the previous header; int_parity unchanged.
4. fifo_full=1 while ld_state with data_in=22 -> dout holds 11, hold_valid=1; then laf_state -> dout=22, hold_valid=0; the parity byte arriving while full sets parity_done.
5. With ROUTER_REG_LEN_CHECK_EN: header 8'h11 (len 4, addr 1), 3 payload bytes, correct parity -> err=0, len_err=1; without the macro, len_err=0.
6. resetn low for 1 cycle after 2 payload bytes -> all outputs 0 immediately; the next packet's err and byte_cnt are computed from zero.
